// File: rtl/carrier_nco.sv
// carrier_nco: quadrature carrier generator for the BPSK transmit path.
//
// A phase accumulator advanced by step_sig feeds two quarter-wave ROM lookups
// that produce sine and cosine. A phase offset is added before the lookup.
// BPSK polarity from data_sig is latched only on a carrier-period carry, so
// phase inversions always land on a period boundary.
//
// Pipeline: stage 0 holds the phase, stage 1 holds the ROM address and sign,
// stage 2 holds the signed output. Latency from phase/offset/polarity to the
// output is two edges.
//
// Ports:
//   clk_sig     clock
//   rst_n       synchronous active-low reset
//   en_sig      advance phase and emit a sample this cycle
//   step_sig    phase increment per enabled cycle (P bits, mod 4*NUM)
//   offset_sig  phase offset added before lookup (P bits)
//   data_sig    BPSK bit, 1 = inverted carrier
//   sin_sig     signed sine sample (WIDTH bits)
//   cos_sig     signed cosine sample (WIDTH bits)
//   valid_sig   output sample is new
//   wrap_sig    output sample is the first of a new carrier period

// carrier_rom: quarter-wave sine table, rom[k] = round((2^W-1)*sin(pi*k/(2*(DEPTH-1)))).
//   addr  table index (0..DEPTH-1 used; padding entries read 0)
//   data  unsigned magnitude, W bits
module carrier_rom #(
    parameter int W     = 15,
    parameter int DEPTH = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  data
);
    localparam real PI = 3.14159265358979323846;

    logic [W-1:0] tbl [2**AW];

    // Table is fixed at elaboration; real math only runs as constant folding.
    for (genvar k = 0; k < 2**AW; k++) begin : g_tbl
        if (k < DEPTH) begin : g_val
            localparam real ANG = PI * k / (2.0 * (DEPTH - 1));
            localparam real AMP = ((2.0 ** W) - 1.0) * $sin(ANG);
            assign tbl[k] = W'($rtoi(AMP + 0.5));
        end else begin : g_pad
            assign tbl[k] = '0;
        end
    end

    assign data = tbl[addr];
endmodule

module carrier_nco #(
    parameter int WIDTH = 16,
    parameter int NUM   = 2,
    localparam int P    = $clog2(NUM) + 2
) (
    input  logic                    clk_sig,
    input  logic                    rst_n,
    input  logic                    en_sig,
    input  logic [P-1:0]            step_sig,
    input  logic [P-1:0]            offset_sig,
    input  logic                    data_sig,
    output logic signed [WIDTH-1:0] sin_sig,
    output logic signed [WIDTH-1:0] cos_sig,
    output logic                    valid_sig,
    output logic                    wrap_sig
);
    localparam int AW = P - 1;   // address range 0..NUM
    localparam int OW = P - 2;   // offset within a quadrant

    // ---------------- stage 0: phase accumulator ----------------
    logic [P-1:0] phase_reg;
    logic         pol_reg;
    logic         wrap0;
    logic [P:0]   sum0;

    assign sum0 = {1'b0, phase_reg} + {1'b0, step_sig};

    always_ff @(posedge clk_sig) begin
        if (!rst_n) begin
            phase_reg <= '0;
            pol_reg   <= 1'b0;
            wrap0     <= 1'b0;
        end else if (en_sig) begin
            phase_reg <= sum0[P-1:0];
            wrap0     <= sum0[P];
            // Polarity only changes at a period boundary.
            if (sum0[P])
                pol_reg <= data_sig;
        end else begin
            wrap0 <= 1'b0;
        end
    end

    // ---------------- stage 1: quadrant folding ----------------
    logic [P-1:0] e_s, e_c;
    logic [AW-1:0] addr_s, addr_c;
    logic          neg_s, neg_c;
    logic          v1, w1;

    assign e_s = phase_reg + offset_sig;
    assign e_c = e_s + P'(NUM);   // cosine leads sine by a quarter period

    // Odd quadrants walk the table backwards; o=0 there maps to the peak.
    function automatic logic [AW-1:0] quad_addr(input logic [P-1:0] e);
        logic [AW-1:0] o;
        o = AW'(e[OW-1:0]);
        return e[P-2] ? (AW'(NUM) - o) : o;
    endfunction

    always_ff @(posedge clk_sig) begin
        if (!rst_n) begin
            addr_s <= '0;
            addr_c <= '0;
            neg_s  <= 1'b0;
            neg_c  <= 1'b0;
            v1     <= 1'b0;
            w1     <= 1'b0;
        end else begin
            addr_s <= quad_addr(e_s);
            addr_c <= quad_addr(e_c);
            neg_s  <= e_s[P-1] ^ pol_reg;
            neg_c  <= e_c[P-1] ^ pol_reg;
            v1     <= en_sig;
            w1     <= wrap0 & en_sig;
        end
    end

    // ---------------- stage 2: ROM lookup and sign ----------------
    logic [WIDTH-2:0] rom_s, rom_c;
    logic [WIDTH-1:0] mag_s, mag_c;

    carrier_rom #(.W(WIDTH-1), .DEPTH(NUM+1)) u_rom_sin (.addr(addr_s), .data(rom_s));
    carrier_rom #(.W(WIDTH-1), .DEPTH(NUM+1)) u_rom_cos (.addr(addr_c), .data(rom_c));

    assign mag_s = {1'b0, rom_s};
    assign mag_c = {1'b0, rom_c};

    // Magnitude never exceeds 2^(WIDTH-1)-1, so negation cannot overflow.
    always_ff @(posedge clk_sig) begin
        if (!rst_n) begin
            sin_sig   <= '0;
            cos_sig   <= '0;
            valid_sig <= 1'b0;
            wrap_sig  <= 1'b0;
        end else begin
            sin_sig   <= neg_s ? -mag_s : mag_s;
            cos_sig   <= neg_c ? -mag_c : mag_c;
            valid_sig <= v1;
            wrap_sig  <= w1;
        end
    end
endmodule

// File: tb/tb_carrier_nco.sv
// Directed bench for carrier_nco: default NUM=2/WIDTH=16 instance plus a
// NUM=8/WIDTH=12 instance for the parameter sweep.
module tb_carrier_nco;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, data;
    logic [2:0] step, offset;
    logic signed [15:0] sin_v, cos_v;
    logic valid, wrap;

    logic en2, data2;
    logic [4:0] step2, offset2;
    logic signed [11:0] sin2, cos2;
    logic valid2, wrap2;

    carrier_nco #(.WIDTH(16), .NUM(2)) dut (
        .clk_sig(clk), .rst_n(rst_n), .en_sig(en), .step_sig(step),
        .offset_sig(offset), .data_sig(data), .sin_sig(sin_v), .cos_sig(cos_v),
        .valid_sig(valid), .wrap_sig(wrap)
    );

    carrier_nco #(.WIDTH(12), .NUM(8)) dut2 (
        .clk_sig(clk), .rst_n(rst_n), .en_sig(en2), .step_sig(step2),
        .offset_sig(offset2), .data_sig(data2), .sin_sig(sin2), .cos_sig(cos2),
        .valid_sig(valid2), .wrap_sig(wrap2)
    );

    int n_chk = 0;
    int n_err = 0;

    // One period of the NUM=2 sine, indexed by phase.
    int tbl [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

    // Enable-gap vectors: en per cycle and the sample each cycle produces.
    int gap_en [8] = '{1, 1, 0, 0, 1, 0, 1, 1};
    int gap_s  [8] = '{0, 23170, 32767, 32767, 32767, 23170, 23170, 0};
    int gap_c  [8] = '{32767, 23170, 0, 0, 0, -23170, -23170, -32767};

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0;
        data = 1'b0; data2 = 1'b0;
        step = 3'd1; offset = 3'd0; step2 = 5'd1; offset2 = 5'd0;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        int n, sg, m;

        // ---- reset state ----
        do_reset;
        chk("rst_sin", sin_v, 0);
        chk("rst_cos", cos_v, 0);
        chk("rst_valid", valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_sin2", sin2, 0);
        chk("rst_valid2", valid2, 0);

        // ---- basic sine, step 1 ----
        en = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick;
            if (k == 1) begin
                chk("basic_valid_lat", valid, 0);
            end else begin
                n = k - 2;
                chk("basic_sin", sin_v, tbl[n % 8]);
                chk("basic_cos", cos_v, tbl[(n + 2) % 8]);
                chk("basic_valid", valid, 1);
                chk("basic_wrap", wrap, int'(n > 0 && n % 8 == 0));
            end
        end

        // ---- BPSK flip mid-period ----
        do_reset;
        en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (k == 5) data = 1'b1;
            tick;
            if (k >= 2) begin
                n = k - 2;
                sg = (n >= 8) ? -1 : 1;
                chk("bpsk_sin", sin_v, sg * tbl[n % 8]);
                chk("bpsk_cos", cos_v, sg * tbl[(n + 2) % 8]);
                chk("bpsk_wrap", wrap, int'(n == 8));
            end
        end

        // ---- step 2 ----
        do_reset;
        step = 3'd2; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k >= 2) begin
                n = k - 2;
                chk("step2_sin", sin_v, tbl[(2 * n) % 8]);
                chk("step2_wrap", wrap, int'(n > 0 && n % 4 == 0));
            end
        end

        // ---- offset 2 ----
        do_reset;
        offset = 3'd2; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k >= 2) begin
                n = k - 2;
                chk("ofs_sin", sin_v, tbl[(n + 2) % 8]);
                chk("ofs_cos", cos_v, tbl[(n + 4) % 8]);
            end
        end

        // ---- enable gaps ----
        do_reset;
        for (int c = 0; c <= 8; c++) begin
            en = (c < 8) ? gap_en[c][0] : 1'b1;
            tick;
            if (c >= 1) begin
                chk("gap_valid", valid, gap_en[c-1]);
                chk("gap_sin", sin_v, gap_s[c-1]);
                chk("gap_cos", cos_v, gap_c[c-1]);
            end
        end

        // ---- reset mid-stream ----
        do_reset;
        en = 1'b1;
        for (int k = 1; k <= 5; k++) tick;
        chk("mid_pre_sin", sin_v, 23170);
        rst_n = 1'b0;
        tick;
        chk("mid_rst_sin", sin_v, 0);
        chk("mid_rst_cos", cos_v, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_wrap", wrap, 0);
        rst_n = 1'b1; en = 1'b0;
        tick; tick;
        chk("mid_idle_valid", valid, 0);
        chk("mid_idle_sin", sin_v, 0);
        en = 1'b1;
        tick;
        chk("mid_lat_valid", valid, 0);
        tick;
        chk("mid_first_valid", valid, 1);
        chk("mid_first_sin", sin_v, 0);
        chk("mid_first_cos", cos_v, 32767);
        tick;
        chk("mid_second_sin", sin_v, 23170);
        chk("mid_second_cos", cos_v, 23170);

        // ---- parameter sweep NUM=8 WIDTH=12 ----
        do_reset;
        en2 = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick;
            if (k >= 2) begin
                n = k - 2;
                m = int'(sin2) * int'(sin2) + int'(cos2) * int'(cos2);
                chk("sweep_mag", int'(m >= 4190209 - 3000 && m <= 4190209 + 3000), 1);
                chk("sweep_range", int'(sin2 <= 2047 && sin2 >= -2047), 1);
                chk("sweep_valid", valid2, 1);
                chk("sweep_wrap", wrap2, int'(n == 32));
                case (n)
                    0:  begin chk("sweep_s0", sin2, 0); chk("sweep_c0", cos2, 2047); end
                    1:  chk("sweep_s1", sin2, 399);
                    3:  chk("sweep_s3", sin2, 1137);
                    7:  chk("sweep_s7", sin2, 2008);
                    8:  chk("sweep_peak", sin2, 2047);
                    16: begin chk("sweep_s16", sin2, 0); chk("sweep_c16", cos2, -2047); end
                    17: chk("sweep_s17", sin2, -399);
                    24: chk("sweep_trough", sin2, -2047);
                    32: chk("sweep_s32", sin2, 0);
                    default: ;
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
